div_ctrl: RTL
=============

Name: div_ctrl

Overview:
- Requester-side controller for the iterative 64-bit divider in the EXU. Implements RV64M DIV/DIVU/REM/REMU and the W variants.
- Accepts one operation at a time from issue and prepares operands for W ops.
- Resolves divide-by-zero and signed overflow locally without using the divider.
- Drives the divider's valid/ready request, captures its one-cycle result pulse, and presents the result to writeback over a valid/ready handshake.

Parameters:
- TAG_W, 5, width of the destination-register tag carried through with the operation.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill the in-flight operation
- req_valid  in  1  issue request valid
- req_ready  out  1  controller can accept a request
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_word  in  1  W variant (32-bit)
- req_src1  in  64  dividend
- req_src2  in  64  divisor
- req_tag  in  TAG_W  destination tag
- resp_valid  out  1  result valid
- resp_ready  in  1  writeback accepts the result
- resp_data  out  64  result
- resp_tag  out  TAG_W  tag of the result
- div_x  out  64  dividend to the divider
- div_y  out  64  divisor to the divider
- div_signed  out  1  signed divide
- div_valid  out  1  divider request
- div_ready  in  1  divider can accept
- div_out_valid  in  1  one-cycle result pulse from the divider
- div_quot  in  64  quotient from the divider
- div_rem  in  64  remainder from the divider

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; div_valid=0; resp_data=0; resp_tag=0; div_x=0; div_y=0; div_signed=0. Reset mid-operation returns to IDLE immediately.
  - Reset does not wait for the divider. Reset is shared, so the divider resets in the same cycle.
- Request acceptance:
  - req_ready = (state==IDLE) & ~flush.
  - A request is accepted when req_valid & req_ready; op, word, tag and prepared operands are latched.
- Operand preparation:
  - Signed ops (DIV, REM): W variant sign-extends src[31:0].
  - Unsigned ops (DIVU, REMU): W variant zero-extends src[31:0].
  - Non-W ops pass the operands through unchanged.
  - div_signed = ~req_op[0].
- Special cases (bypass, checked on the prepared operands at accept):
  - Zero divisor: quotient = all ones, remainder = prepared dividend.
  - Overflow (signed op, dividend = most negative value, divisor = -1):
    - 64-bit: 0x8000000000000000.
    - W: prepared value 0xFFFFFFFF80000000.
    - Result: quotient = dividend, remainder = 0.
  - On bypass: IDLE -> RESP; resp_valid rises the cycle after accept; div_valid is never asserted.
- Result selection: REM/REMU take the remainder, otherwise the quotient. W ops sign-extend bit 31 of the selected value, for both signed and unsigned ops.
- State machine:
  - IDLE -> ISSUE on a non-bypass accept.
  - ISSUE: div_valid=1 with div_x/div_y/div_signed held stable. On div_valid & div_ready -> WAIT.
  - WAIT: on div_out_valid, capture the selected result into resp_data -> RESP.
  - RESP: resp_valid=1 with resp_data/resp_tag stable. On resp_ready -> IDLE.
  - DRAIN: the divider is busy on a killed operation. On div_out_valid the result is discarded -> IDLE.
- Flush (the divider cannot be aborted):
  - IDLE: request refused.
  - ISSUE without handshake that cycle: -> IDLE.
  - ISSUE with handshake the same cycle: -> DRAIN.
  - WAIT without div_out_valid: -> DRAIN.
  - WAIT with div_out_valid the same cycle: -> IDLE.
  - RESP: response dropped -> IDLE.
  - DRAIN: stays in DRAIN.
- Latency:
  - Bypass: 1 cycle.
  - Normal: resp_valid rises the cycle after div_out_valid.
- Throughput: one operation in flight; no new request until the current one leaves RESP or DRAIN.

Optional Feature:
- Macro: DIVCTL_RESULT_CACHE_EN.
- With the macro defined:
  - Store prepared src1, prepared src2, div_signed, word, quotient and remainder of the last completed (not discarded) divider operation.
  - A later accept with identical prepared src1/src2/div_signed/word hits. This covers DIV followed by REM on the same operands.
  - On a hit, go IDLE -> RESP with a 1-cycle latency and no div_valid.
  - The cache entry is cleared by reset only; flush does not clear it.
- Without the macro: no cache storage; every non-bypass operation goes through the divider.

Test Plan:
- DIV src1=-7 (0xFFFFFFFFFFFFFFF9), src2=2 -> resp_data 0xFFFFFFFFFFFFFFFD. REM with the same operands -> 0xFFFFFFFFFFFFFFFF. resp_tag equals req_tag.
- DIVU src1=0x1234, src2=0 -> 0xFFFFFFFFFFFFFFFF one cycle after accept, div_valid never high. REMU with the same operands -> 0x1234.
- DIV src1=0x8000000000000000, src2=0xFFFFFFFFFFFFFFFF -> 0x8000000000000000 via bypass. REMW src1=0x80000000, src2=0xFFFFFFFF -> 0.
- DIVUW src1=0xAAAA5555FFFFFFFE, src2=2 -> 0x000000007FFFFFFF. REMW src1=0x12345678FFFFFFF9, src2=2 -> 0xFFFFFFFFFFFFFFFF.
- Flush one cycle after the divider handshake -> DRAIN, no resp_valid, req_ready low until div_out_valid. The next DIVU 100/7 -> 14.
- Hold resp_ready low for 10 cycles in RESP -> resp_valid, resp_data and resp_tag stable, req_ready=0. With DIVCTL_RESULT_CACHE_EN defined, a follow-up REM 100/7 -> 2 with 1-cycle latency and no div_valid.

Source files
------------

// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - issue, writeback and divider handshake bundle for div_ctrl.
// master is the controller side; slave is the surrounding issue/writeback/divider side.
interface div_ctrl_if #(
  parameter int TAG_W = 5
) ();
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic             req_word;
  logic [63:0]      req_src1;
  logic [63:0]      req_src2;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [63:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic [63:0]      div_x;
  logic [63:0]      div_y;
  logic             div_signed;
  logic             div_valid;
  logic             div_ready;
  logic             div_out_valid;
  logic [63:0]      div_quot;
  logic [63:0]      div_rem;

  modport master (
    input  req_valid, req_op, req_word, req_src1, req_src2, req_tag, resp_ready,
           div_ready, div_out_valid, div_quot, div_rem,
    output req_ready, resp_valid, resp_data, resp_tag, div_x, div_y, div_signed, div_valid
  );

  modport slave (
    output req_valid, req_op, req_word, req_src1, req_src2, req_tag, resp_ready,
           div_ready, div_out_valid, div_quot, div_rem,
    input  req_ready, resp_valid, resp_data, resp_tag, div_x, div_y, div_signed, div_valid
  );
endinterface

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - RV64M divide requester: W operand prep, x/0 and overflow bypass, divider handshake.
// Define DIVCTL_RESULT_CACHE_EN to reuse the last completed divider result on a repeat-operand request.
module div_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  div_ctrl_if.master bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [63:0]      div_x_q, div_x_d, div_y_q, div_y_d;
  logic [63:0]      resp_data_q, resp_data_d;
  logic             div_signed_q, div_signed_d;
  logic             rem_sel_q, rem_sel_d;
  logic             word_q, word_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

  logic [63:0] x_prep, y_prep, min_neg, byp_quot, byp_rem, hit_quot, hit_rem;
  logic        sgn, accept, zero_div, ovf, bypass, hit, div_hs;

  function automatic logic [63:0] prep(input logic [63:0] v, input logic w, input logic s);
    if (!w) return v;
    return s ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
  endfunction

  // W results are sign-extended from bit 31 even for the unsigned ops.
  function automatic logic [63:0] sel_result(input logic [63:0] q, input logic [63:0] r,
                                             input logic rem, input logic w);
    logic [63:0] v;
    v = rem ? r : q;
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  always_comb begin
    sgn      = ~bus.req_op[0];
    x_prep   = prep(bus.req_src1, bus.req_word, sgn);
    y_prep   = prep(bus.req_src2, bus.req_word, sgn);
    min_neg  = bus.req_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    zero_div = (y_prep == 64'd0);
    ovf      = sgn & (x_prep == min_neg) & (&y_prep);
    bypass   = zero_div | ovf;
    byp_quot = zero_div ? {64{1'b1}} : x_prep;
    byp_rem  = zero_div ? x_prep : 64'd0;
  end

  assign bus.req_ready  = (state_q == S_IDLE) & ~flush;
  assign accept         = bus.req_valid & bus.req_ready;
  assign div_hs         = bus.div_valid & bus.div_ready;
  assign bus.div_valid  = (state_q == S_ISSUE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_tag   = resp_tag_q;
  assign bus.div_x      = div_x_q;
  assign bus.div_y      = div_y_q;
  assign bus.div_signed = div_signed_q;

`ifdef DIVCTL_RESULT_CACHE_EN
  logic        cache_vld_q, cache_vld_d, cache_sgn_q, cache_sgn_d, cache_word_q, cache_word_d;
  logic [63:0] cache_x_q, cache_x_d, cache_y_q, cache_y_d;
  logic [63:0] cache_quot_q, cache_quot_d, cache_rem_q, cache_rem_d;

  assign hit = cache_vld_q & (cache_x_q == x_prep) & (cache_y_q == y_prep) &
               (cache_sgn_q == sgn) & (cache_word_q == bus.req_word);
  assign hit_quot = cache_quot_q;
  assign hit_rem  = cache_rem_q;

  // Only results actually delivered are kept; drained results may belong to a killed op.
  always_comb begin
    cache_vld_d  = cache_vld_q;
    cache_sgn_d  = cache_sgn_q;
    cache_word_d = cache_word_q;
    cache_x_d    = cache_x_q;
    cache_y_d    = cache_y_q;
    cache_quot_d = cache_quot_q;
    cache_rem_d  = cache_rem_q;
    if ((state_q == S_WAIT) && bus.div_out_valid && !flush) begin
      cache_vld_d  = 1'b1;
      cache_sgn_d  = div_signed_q;
      cache_word_d = word_q;
      cache_x_d    = div_x_q;
      cache_y_d    = div_y_q;
      cache_quot_d = bus.div_quot;
      cache_rem_d  = bus.div_rem;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_vld_q  <= 1'b0;
      cache_sgn_q  <= 1'b0;
      cache_word_q <= 1'b0;
      cache_x_q    <= 64'd0;
      cache_y_q    <= 64'd0;
      cache_quot_q <= 64'd0;
      cache_rem_q  <= 64'd0;
    end else begin
      cache_vld_q  <= cache_vld_d;
      cache_sgn_q  <= cache_sgn_d;
      cache_word_q <= cache_word_d;
      cache_x_q    <= cache_x_d;
      cache_y_q    <= cache_y_d;
      cache_quot_q <= cache_quot_d;
      cache_rem_q  <= cache_rem_d;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_quot = 64'd0;
  assign hit_rem  = 64'd0;
`endif

  always_comb begin
    state_d      = state_q;
    div_x_d      = div_x_q;
    div_y_d      = div_y_q;
    div_signed_d = div_signed_q;
    rem_sel_d    = rem_sel_q;
    word_d       = word_q;
    resp_tag_d   = resp_tag_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          div_x_d      = x_prep;
          div_y_d      = y_prep;
          div_signed_d = sgn;
          rem_sel_d    = bus.req_op[1];
          word_d       = bus.req_word;
          resp_tag_d   = bus.req_tag;
          if (bypass) begin
            resp_data_d = sel_result(byp_quot, byp_rem, bus.req_op[1], bus.req_word);
            state_d     = S_RESP;
          end else if (hit) begin
            resp_data_d = sel_result(hit_quot, hit_rem, bus.req_op[1], bus.req_word);
            state_d     = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      // The divider cannot be aborted, so a kill after its handshake must wait it out.
      S_ISSUE: begin
        if (flush)       state_d = div_hs ? S_DRAIN : S_IDLE;
        else if (div_hs) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.div_out_valid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            resp_data_d = sel_result(bus.div_quot, bus.div_rem, rem_sel_q, word_q);
            state_d     = S_RESP;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_RESP:  if (flush || bus.resp_ready) state_d = S_IDLE;
      S_DRAIN: if (bus.div_out_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_x_q      <= 64'd0;
      div_y_q      <= 64'd0;
      div_signed_q <= 1'b0;
      rem_sel_q    <= 1'b0;
      word_q       <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= 64'd0;
    end else begin
      state_q      <= state_d;
      div_x_q      <= div_x_d;
      div_y_q      <= div_y_d;
      div_signed_q <= div_signed_d;
      rem_sel_q    <= rem_sel_d;
      word_q       <= word_d;
      resp_tag_q   <= resp_tag_d;
      resp_data_q  <= resp_data_d;
    end
  end
endmodule
